icache: RTL and testbench

//  Direct-mapped instruction cache between ifetch (upstream consumer) and the memory controller.

---
 rtl/icache.sv | 159 +++++++++++++++
 tb/tb_icache.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache: 1-cycle hits, word-by-word line refill, and support for
// 32-bit instructions that straddle two words or two lines (RVC aware).
module icache #(
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        fetch_req,
   input  logic [31:0] fetch_pc,
   output logic        have_result,
   output logic [31:0] inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data
);
   localparam int LINES     = 1 << INDEX_BITS;
   localparam int WORDS     = 1 << OFFSET_BITS;
   localparam int TAG_BITS  = 30 - INDEX_BITS - OFFSET_BITS;
   localparam int BASE_BITS = 30 - OFFSET_BITS;
   localparam int SLOT_BITS = INDEX_BITS + OFFSET_BITS;
   localparam logic [OFFSET_BITS-1:0] CNT_ONE  = OFFSET_BITS'(1);
   localparam logic [OFFSET_BITS-1:0] CNT_LAST = OFFSET_BITS'(WORDS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, CHECK = 2'd2} state_t;

   state_t                 state_r;
   logic [31:0]            data_r [LINES*WORDS];
   logic [TAG_BITS-1:0]    tag_r [LINES];
   logic [LINES-1:0]       valid_r;
   logic [31:1]            pc_r;
   logic                   lo_valid_r;
   logic [31:0]            lo_word_r;
   logic [BASE_BITS-1:0]   refill_base_r;
   logic [OFFSET_BITS-1:0] cnt_r;

   logic [31:1]            pc_s;
   logic [29:0]            w0_s;
   logic [29:0]            w1_s;
   logic                   hit0_s;
   logic                   hit1_s;
   logic                   w0_ok_s;
   logic [31:0]            word0_s;
   logic [15:0]            word1_lo_s;
   logic [15:0]            lo16_s;
   logic [15:0]            hi16_s;
   logic                   need1_s;
   logic                   all_hit_s;
   logic [BASE_BITS-1:0]   miss_base_s;
   logic                   unused_s;

   assign unused_s = fetch_pc[0];

   // Lookup of the request (IDLE) or of the latched PC (CHECK); w0's word may come from the latch
   always_comb begin
      if (state_r == CHECK) begin
         pc_s = pc_r;
      end else begin
         pc_s = fetch_pc[31:1];
      end
      w0_s       = pc_s[31:2];
      w1_s       = w0_s + 30'd1;
      hit0_s     = valid_r[w0_s[SLOT_BITS-1 -: INDEX_BITS]] &&
                   (tag_r[w0_s[SLOT_BITS-1 -: INDEX_BITS]] == w0_s[29 -: TAG_BITS]);
      hit1_s     = valid_r[w1_s[SLOT_BITS-1 -: INDEX_BITS]] &&
                   (tag_r[w1_s[SLOT_BITS-1 -: INDEX_BITS]] == w1_s[29 -: TAG_BITS]);
      word1_lo_s = data_r[w1_s[SLOT_BITS-1:0]][15:0];
      if (lo_valid_r) begin
         word0_s = lo_word_r;
      end else begin
         word0_s = data_r[w0_s[SLOT_BITS-1:0]];
      end
      w0_ok_s = lo_valid_r || hit0_s;
      if (pc_s[1]) begin
         lo16_s = word0_s[31:16];
      end else begin
         lo16_s = word0_s[15:0];
      end
      need1_s = pc_s[1] && (lo16_s[1:0] == 2'b11);
      if (lo16_s[1:0] != 2'b11) begin
         hi16_s = 16'h0000;
      end else if (pc_s[1]) begin
         hi16_s = word1_lo_s;
      end else begin
         hi16_s = word0_s[31:16];
      end
      all_hit_s = w0_ok_s && (!need1_s || hit1_s);
      if (!w0_ok_s) begin
         miss_base_s = w0_s[29:OFFSET_BITS];
      end else begin
         miss_base_s = w1_s[29:OFFSET_BITS];
      end
   end

   // Control FSM, line storage and registered outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r       <= IDLE;
         valid_r       <= '0;
         have_result   <= 1'b0;
         inst          <= 32'h0000_0000;
         mem_req       <= 1'b0;
         mem_addr      <= 32'h0000_0000;
         pc_r          <= 31'h0000_0000;
         lo_valid_r    <= 1'b0;
         lo_word_r     <= 32'h0000_0000;
         refill_base_r <= '0;
         cnt_r         <= '0;
      end else if (rdy_in) begin
         have_result <= 1'b0;
         case (state_r)
            IDLE, CHECK: begin
               if (state_r == CHECK || fetch_req) begin
                  if (all_hit_s) begin
                     have_result <= 1'b1;
                     inst        <= {hi16_s, lo16_s};
                     lo_valid_r  <= 1'b0;
                     state_r     <= IDLE;
                  end else begin
                     // w0's word is kept aside so w1's refill may safely evict its line
                     pc_r          <= pc_s;
                     lo_valid_r    <= w0_ok_s;
                     lo_word_r     <= word0_s;
                     refill_base_r <= miss_base_s;
                     cnt_r         <= '0;
                     mem_req       <= 1'b1;
                     mem_addr      <= {miss_base_s, {OFFSET_BITS{1'b0}}, 2'b00};
                     state_r       <= REFILL;
                  end
               end
            end
            REFILL: begin
               if (mem_req) begin
                  if (mem_done) begin
                     data_r[{refill_base_r[INDEX_BITS-1:0], cnt_r}] <= mem_data;
                     mem_req <= 1'b0;
                     if (cnt_r == CNT_LAST) begin
                        tag_r[refill_base_r[INDEX_BITS-1:0]]   <= refill_base_r[BASE_BITS-1 -: TAG_BITS];
                        valid_r[refill_base_r[INDEX_BITS-1:0]] <= 1'b1;
                        state_r <= CHECK;
                     end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                     end
                  end
               end else begin
                  mem_req  <= 1'b1;
                  mem_addr <= {refill_base_r, cnt_r, 2'b00};
               end
            end
            default: begin
               state_r <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache: memory responder with variable latency and a
// line-presence reference model predicting refill addresses, instruction words and hit latency.
module tb_icache;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_pc = 32'h0;
   logic        have_result;
   logic [31:0] inst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done = 1'b0;
   logic [31:0] mem_data = 32'h0;

   icache dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .have_result(have_result), .inst(inst),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_done(mem_done), .mem_data(mem_data)
   );

   always #5 clk_in = ~clk_in;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          fixed_lat = -1;
   logic [31:0] override_mem [logic [31:0]];
   logic [31:0] addr_log [$];
   logic [31:0] exp_addrs [$];
   logic [31:0] model_line [16];
   bit          model_valid [16];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (override_mem.exists(a)) return override_mem[a];
      return (a * 32'h9E37_79B1) ^ (a >> 3) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [15:0] half(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word({a[31:2], 2'b00});
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
   endfunction

   // a needed line not present is refilled word by word, replacing whatever shares its index
   function automatic void model_touch(input logic [31:0] line);
      int idx;
      idx = int'((line >> 4) & 32'hF);
      if (!(model_valid[idx] && model_line[idx] == line)) begin
         for (int k = 0; k < 4; k++) exp_addrs.push_back(line + 32'(k * 4));
         model_valid[idx] = 1'b1;
         model_line[idx]  = line;
      end
   endfunction

   // memory controller: answers each request after 0..3 cycles, never while paused or in reset
   initial begin
      bit          pending = 1'b0;
      bit          prev_req = 1'b0;
      bit          prev_done = 1'b0;
      logic [31:0] prev_addr = 32'h0;
      int          wait_cnt = 0;
      forever begin
         @(negedge clk_in); #1;
         mem_done = 1'b0;
         if (rst_in) begin
            pending = 1'b0; prev_req = 1'b0; prev_done = 1'b0;
         end else if (rdy_in) begin
            if (prev_done) check_eq("mem_gap", 32'(mem_req), 32'h0);
            else if (prev_req && mem_req) check_eq("mem_addr_stable", mem_addr, prev_addr);
            if (mem_req && !prev_done) begin
               if (!pending) begin
                  pending  = 1'b1;
                  wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
               end
               if (wait_cnt == 0) begin
                  mem_done = 1'b1;
                  mem_data = mem_word(mem_addr);
                  addr_log.push_back(mem_addr);
                  pending  = 1'b0;
               end else begin
                  wait_cnt--;
               end
            end
            prev_req = mem_req; prev_addr = mem_addr; prev_done = mem_done;
         end
      end
   end

   task automatic do_reset();
      rst_in = 1'b1; fetch_req = 1'b0; rdy_in = 1'b1;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      model_clear();
      addr_log.delete();
   endtask

   task automatic do_fetch(input logic [31:0] pc, input int pause_at, output int cycles);
      logic [15:0] lo;
      logic [31:0] exp_inst;
      logic [31:0] pc2;
      logic [31:0] ref_addr;
      logic        ref_req;
      lo  = half(pc);
      pc2 = pc + 32'd2;
      exp_inst = (lo[1:0] == 2'b11) ? {half(pc2), lo} : {16'h0000, lo};
      exp_addrs.delete();
      model_touch(pc & 32'hFFFF_FFF0);
      if (pc[1] && lo[1:0] == 2'b11) model_touch(pc2 & 32'hFFFF_FFF0);
      addr_log.delete();
      @(negedge clk_in);
      fetch_req = 1'b1; fetch_pc = pc;
      @(negedge clk_in);
      fetch_req = 1'b0; fetch_pc = {$urandom, 1'b0} >> 1 << 1;
      cycles = 1;
      while (have_result !== 1'b1 && cycles < 400) begin
         if (cycles == pause_at) begin
            ref_req = mem_req; ref_addr = mem_addr; rdy_in = 1'b0;
            repeat (5) begin
               @(negedge clk_in); cycles++;
               check_eq("pause_mem_req", 32'(mem_req), 32'(ref_req));
               check_eq("pause_mem_addr", mem_addr, ref_addr);
            end
            rdy_in = 1'b1;
         end
         @(negedge clk_in); cycles++;
      end
      check_eq("result_seen", 32'(have_result), 32'h1);
      check_eq("inst", inst, exp_inst);
      check_eq("req_count", 32'(addr_log.size()), 32'(exp_addrs.size()));
      for (int i = 0; i < addr_log.size() && i < exp_addrs.size(); i++)
         check_eq("req_addr", addr_log[i], exp_addrs[i]);
      if (exp_addrs.size() == 0) check_eq("hit_latency", 32'(cycles), 32'h1);
      @(negedge clk_in);
      check_eq("result_pulse", 32'(have_result), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, k;
      override_mem[32'h0000_0000] = 32'h00A0_0093;
      override_mem[32'h0000_000C] = 32'h4505_0001;
      override_mem[32'h0000_004C] = 32'h0517_1234;
      override_mem[32'h0000_0050] = 32'hBEEF_0297;

      do_reset();
      check_eq("reset_have_result", 32'(have_result), 32'h0);
      check_eq("reset_inst", inst, 32'h0);
      check_eq("reset_mem_req", 32'(mem_req), 32'h0);
      check_eq("reset_mem_addr", mem_addr, 32'h0);

      // cold fetch, then hit, then index conflict
      do_fetch(32'h0, -1, c0);
      check_eq("t1_inst", inst, 32'h00A0_0093);
      do_fetch(32'h0, -1, c0);
      check_eq("t1_hit_reqs", 32'(addr_log.size()), 32'h0);
      do_fetch(32'h100, -1, c0);
      do_fetch(32'h0, -1, c0);
      check_eq("t4_refetch_reqs", 32'(addr_log.size()), 32'h4);

      // RVC in the last halfword of a line, then a 32-bit instruction straddling lines
      do_reset();
      do_fetch(32'h0E, -1, c0);
      check_eq("t2_inst", inst, 32'h0000_4505);
      do_fetch(32'h4E, -1, c0);
      check_eq("t3_inst", inst, 32'h0297_0517);
      check_eq("t3_reqs", 32'(addr_log.size()), 32'h8);

      // pause mid-refill costs exactly the paused cycles
      fixed_lat = 1;
      do_reset();
      do_fetch(32'h200, -1, c0);
      do_reset();
      do_fetch(32'h200, 6, c1);
      check_eq("pause_extra_cycles", 32'(c1), 32'(c0 + 5));
      fixed_lat = -1;

      // reset during the second word of a refill abandons it
      do_reset();
      @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h340;
      @(negedge clk_in); fetch_req = 1'b0;
      k = 0;
      while (!(addr_log.size() == 1 && mem_req) && k < 100) begin
         @(negedge clk_in); k++;
      end
      check_eq("rst_window", 32'(addr_log.size() == 1 && mem_req), 32'h1);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check_eq("rst_mem_req", 32'(mem_req), 32'h0);
      repeat (3) @(negedge clk_in);
      check_eq("rst_no_result", 32'(have_result), 32'h0);
      model_clear();
      do_fetch(32'h340, -1, c0);

      // random fetches over a window four times the cache size, with occasional pauses
      for (int n = 0; n < 60; n++) begin
         logic [31:0] pc;
         int          pa;
         pc = 32'($urandom_range(0, 32'h3FF)) & 32'hFFFF_FFFE;
         if ($urandom_range(0, 3) == 0) pc = pc | 32'h0000_000E;
         pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 8)) : -1;
         do_fetch(pc, pa, c0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
